// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Redirect squashes IF/ID to a NOP bubble; stall freezes everything.
module instruction_fetch_unit #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0]      TEXT_BASE  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] ifid_instruction_o,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4_o,
  output logic                  ifid_valid_o
);

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target_aligned;

  // Both sums wrap modulo 2^DATA_WIDTH by construction.
  always_comb begin
    pc_plus4       = pc_o + DATA_WIDTH'(4);
    mem_address_o  = pc_o - TEXT_BASE;
    target_aligned = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_o               <= RESET_PC;
      ifid_instruction_o <= '0;
      ifid_pc_plus4_o    <= '0;
      ifid_valid_o       <= 1'b0;
    end else if (redirect_i) begin
      pc_o               <= target_aligned;
      ifid_instruction_o <= '0;
      ifid_pc_plus4_o    <= '0;
      ifid_valid_o       <= 1'b0;
    end else if (!stall_i) begin
      pc_o               <= pc_plus4;
      ifid_instruction_o <= instruction_i;
      ifid_pc_plus4_o    <= pc_plus4;
      ifid_valid_o       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational program-memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] instruction_i;
  logic [31:0] pc_o;
  logic [31:0] mem_address_o;
  logic [31:0] ifid_instruction_o;
  logic [31:0] ifid_pc_plus4_o;
  logic        ifid_valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Program memory: address 0 holds addi $t0,$zero,5; others are address-tagged words.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0], 16'hBEEF};
  endfunction

  assign instruction_i = mem_model(mem_address_o);

  instruction_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0040_0000),
    .TEXT_BASE (32'h0040_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .instruction_i     (instruction_i),
    .pc_o              (pc_o),
    .mem_address_o     (mem_address_o),
    .ifid_instruction_o(ifid_instruction_o),
    .ifid_pc_plus4_o   (ifid_pc_plus4_o),
    .ifid_valid_o      (ifid_valid_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    step(); step();
    checks++; if (pc_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0040_0000); end
    checks++; if (ifid_instruction_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", ifid_instruction_o, 32'h0); end
    checks++; if (ifid_pc_plus4_o !== 32'h0) begin errors++; $display("FAIL reset_pp4: got %h expected %h", ifid_pc_plus4_o, 32'h0); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid_o); end
    checks++; if (mem_address_o !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h expected %h", mem_address_o, 32'h0); end
  endtask

  task automatic test_fetch();
    reset = 1'b0;
    step();
    checks++; if (ifid_instruction_o !== 32'h2008_0005) begin errors++; $display("FAIL fetch0_instr: got %h expected %h", ifid_instruction_o, 32'h2008_0005); end
    checks++; if (ifid_pc_plus4_o !== 32'h0040_0004) begin errors++; $display("FAIL fetch0_pp4: got %h expected %h", ifid_pc_plus4_o, 32'h0040_0004); end
    checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL fetch0_valid: got %b expected 1", ifid_valid_o); end
    checks++; if (pc_o !== 32'h0040_0004) begin errors++; $display("FAIL fetch0_pc: got %h expected %h", pc_o, 32'h0040_0004); end
    step();
    checks++; if (pc_o !== 32'h0040_0008) begin errors++; $display("FAIL fetch1_pc: got %h expected %h", pc_o, 32'h0040_0008); end
    checks++; if (ifid_instruction_o !== 32'h0004_BEEF) begin errors++; $display("FAIL fetch1_instr: got %h expected %h", ifid_instruction_o, 32'h0004_BEEF); end
    checks++; if (ifid_pc_plus4_o !== 32'h0040_0008) begin errors++; $display("FAIL fetch1_pp4: got %h expected %h", ifid_pc_plus4_o, 32'h0040_0008); end
    step();
    checks++; if (pc_o !== 32'h0040_000C) begin errors++; $display("FAIL fetch2_pc: got %h expected %h", pc_o, 32'h0040_000C); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_o !== 32'h0040_000C) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_o, 32'h0040_000C); end
      checks++; if (ifid_instruction_o !== 32'h0008_BEEF || ifid_pc_plus4_o !== 32'h0040_000C || ifid_valid_o !== 1'b1) begin
        errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected 0008beef/0040000c/1", i, ifid_instruction_o, ifid_pc_plus4_o, ifid_valid_o);
      end
    end
    stall_i = 1'b0;
    step();
    checks++; if (pc_o !== 32'h0040_0010) begin errors++; $display("FAIL unstall_pc: got %h expected %h", pc_o, 32'h0040_0010); end
    checks++; if (ifid_instruction_o !== 32'h000C_BEEF || ifid_pc_plus4_o !== 32'h0040_0010) begin
      errors++; $display("FAIL unstall_ifid: got %h/%h expected 000cbeef/00400010", ifid_instruction_o, ifid_pc_plus4_o);
    end
  endtask

  task automatic test_redirect_stall();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h0040_0020;
    step();
    checks++; if (pc_o !== 32'h0040_0020) begin errors++; $display("FAIL redir_pc: got %h expected %h", pc_o, 32'h0040_0020); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", ifid_valid_o); end
    checks++; if (ifid_instruction_o !== 32'h0 || ifid_pc_plus4_o !== 32'h0) begin
      errors++; $display("FAIL redir_ifid: got %h/%h expected 0/0", ifid_instruction_o, ifid_pc_plus4_o);
    end
    checks++; if (mem_address_o !== 32'h0000_0020) begin errors++; $display("FAIL redir_memaddr: got %h expected %h", mem_address_o, 32'h20); end
    stall_i = 1'b0; redirect_i = 1'b0;
    step();
    checks++; if (ifid_instruction_o !== 32'h0020_BEEF || ifid_pc_plus4_o !== 32'h0040_0024 || ifid_valid_o !== 1'b1) begin
      errors++; $display("FAIL after_redir_ifid: got %h/%h/%b expected 0020beef/00400024/1", ifid_instruction_o, ifid_pc_plus4_o, ifid_valid_o);
    end
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_target_i = 32'h0040_0023;
    step();
    redirect_i = 1'b0;
    checks++; if (pc_o !== 32'h0040_0020) begin errors++; $display("FAIL misaligned_pc: got %h expected %h", pc_o, 32'h0040_0020); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgt [3];
    logic [31:0] exp_pc [3];
    tgt[0] = 32'h0040_0100; tgt[1] = 32'h0040_0202; tgt[2] = 32'h0040_0304;
    exp_pc[0] = 32'h0040_0100; exp_pc[1] = 32'h0040_0200; exp_pc[2] = 32'h0040_0304;
    redirect_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect_target_i = tgt[i];
      step();
      checks++; if (pc_o !== exp_pc[i] || ifid_valid_o !== 1'b0) begin
        errors++; $display("FAIL b2b_redir[%0d]: got pc=%h valid=%b expected pc=%h valid=0", i, pc_o, ifid_valid_o, exp_pc[i]);
      end
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    checks++; if (mem_address_o !== 32'hFFBF_FFFC) begin errors++; $display("FAIL wrap_memaddr_hi: got %h expected %h", mem_address_o, 32'hFFBF_FFFC); end
    step();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc_o, 32'h0); end
    checks++; if (ifid_pc_plus4_o !== 32'h0 || ifid_valid_o !== 1'b1 || ifid_instruction_o !== 32'hFFFC_BEEF) begin
      errors++; $display("FAIL wrap_ifid: got %h/%h/%b expected fffcbeef/00000000/1", ifid_instruction_o, ifid_pc_plus4_o, ifid_valid_o);
    end
    checks++; if (mem_address_o !== 32'hFFC0_0000) begin errors++; $display("FAIL wrap_memaddr_lo: got %h expected %h", mem_address_o, 32'hFFC0_0000); end
  endtask

  task automatic test_reset_override();
    redirect_i = 1'b1; redirect_target_i = 32'h0040_003C;
    step();
    redirect_i = 1'b0;
    step();
    checks++; if (pc_o !== 32'h0040_0040 || ifid_valid_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pc: got %h/%b expected 00400040/1", pc_o, ifid_valid_o);
    end
    stall_i = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++; if (pc_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_stall_pc: got %h expected %h", pc_o, 32'h0040_0000); end
    checks++; if (ifid_instruction_o !== 32'h0 || ifid_pc_plus4_o !== 32'h0 || ifid_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall_ifid: got %h/%h/%b expected 0/0/0", ifid_instruction_o, ifid_pc_plus4_o, ifid_valid_o);
    end
    stall_i = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h0040_0080;
    step();
    checks++; if (pc_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_redir_pc: got %h expected %h", pc_o, 32'h0040_0000); end
    reset = 1'b0; redirect_i = 1'b0;
    step();
    checks++; if (ifid_instruction_o !== 32'h2008_0005 || ifid_pc_plus4_o !== 32'h0040_0004 || ifid_valid_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_fetch: got %h/%h/%b expected 20080005/00400004/1", ifid_instruction_o, ifid_pc_plus4_o, ifid_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of PC, addresses and instructions.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, the PC value loaded on reset (text segment base).
REQ-003 SHALL have parameter TEXT_BASE, default 32'h0040_0000, subtracted from PC to form the program-memory byte address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_i  input  1  hazard unit hold; freezes PC and IF/ID register.
REQ-007 redirect_i  input  1  taken branch/jump resolved downstream; load redirect_target_i and squash IF/ID.
REQ-008 redirect_target_i  input  DATA_WIDTH  byte address of the next instruction on redirect.
REQ-009 instruction_i  input  DATA_WIDTH  combinational instruction returned by program memory for mem_address_o.
REQ-010 pc_o  output  DATA_WIDTH  current fetch PC.
REQ-011 mem_address_o  output  DATA_WIDTH  pc_o - TEXT_BASE, driven combinationally to program memory Address.
REQ-012 ifid_instruction_o  output  DATA_WIDTH  registered instruction for decode.
REQ-013 ifid_pc_plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
REQ-014 ifid_valid_o  output  1  high when ifid_instruction_o is a real fetched instruction.

Function
REQ-015 SHALL evaluate one action per rising edge with priority reset > redirect_i > stall_i > normal advance.
REQ-016 Normal advance: PC <= PC+4; IF/ID <= {instruction_i, PC+4, valid=1}.
REQ-017 Latency: instruction at PC=A SHALL appear on ifid_instruction_o exactly one cycle after pc_o==A, with ifid_pc_plus4_o==A+4.
REQ-018 Stall (redirect_i low): PC and all IF/ID outputs SHALL hold their values, including ifid_valid_o.
REQ-019 Redirect: PC <= {redirect_target_i[DATA_WIDTH-1:2], 2'b00}; IF/ID <= {32'h0000_0000 (NOP), 0, valid=0}.
REQ-020 Redirect and stall asserted together SHALL behave as redirect alone.
REQ-021 Misaligned redirect target: low two bits SHALL be cleared; no error flag.
REQ-022 PC+4 SHALL be computed modulo 2^DATA_WIDTH; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 mem_address_o SHALL be computed modulo 2^DATA_WIDTH; PC below TEXT_BASE wraps, no saturation.
REQ-024 Block SHALL contain no combinational path from stall_i or redirect_i to any output.
REQ-025 Consecutive redirects on back-to-back cycles SHALL each take effect; ifid_valid_o stays 0 throughout.

Reset
REQ-026 On reset high at a rising edge: pc_o=RESET_PC, ifid_instruction_o=0, ifid_pc_plus4_o=0, ifid_valid_o=0; mem_address_o=RESET_PC-TEXT_BASE (0 by default).
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override both; first fetch after deassertion is from RESET_PC.

Verification
REQ-028 Reset, release, memory returns 32'h2008_0005 at address 0 -> next cycle ifid_instruction_o=32'h2008_0005, ifid_pc_plus4_o=32'h0040_0004, ifid_valid_o=1, pc_o=32'h0040_0008 one cycle later.
REQ-029 stall_i high 3 cycles with pc_o=32'h0040_000C -> pc_o and IF/ID constant for 3 cycles, advance to 32'h0040_0010 on first cycle after release.
REQ-030 redirect_i with target 32'h0040_0020 while stall_i high -> pc_o=32'h0040_0020, ifid_valid_o=0, ifid_instruction_o=0, mem_address_o=32'h0000_0020.
REQ-031 redirect target 32'h0040_0023 -> pc_o=32'h0040_0020.
REQ-032 Force PC to 32'hFFFF_FFFC via redirect, advance once -> pc_o=32'h0000_0000, ifid_pc_plus4_o=32'h0000_0000, ifid_valid_o=1.
REQ-033 Assert reset during stall with pc_o=32'h0040_0040 -> pc_o=32'h0040_0000, all IF/ID outputs 0 after the edge.
